uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - Serial receive end of the 8N1 UART link; pairs with the transmit side that drives tx/dintx/donetx.
// - Samples the asynchronous rx line at mid-bit, reassembles bytes LSB-first and presents them on doutrx.
// - Signals each good byte with a one-cycle donerx pulse; flags bad stop bits on frame_err.
// - Sits behind the uart2 modport of uart_if, alongside the transmitter in the loopback/top level.
// PARAMETERS
// - clk_rate   1000000  system clock frequency, Hz
// - baud_rate  9600     line bit rate, bits/s
// - Derived: CPB = clk_rate/baud_rate, truncated (104 at defaults); HALF = CPB/2 (52).
// - Elaboration-time assertion: CPB >= 4.
// PORTS
// - clk        in   1  system clock, all logic on posedge
// - rst        in   1  synchronous, active-high reset
// - rx         in   1  asynchronous serial input, idle high
// - doutrx     out  8  last correctly framed byte, held until the next good byte
// - donerx     out  1  one-cycle pulse: doutrx updated this cycle
// - frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
// - busy       out  1  high while not in IDLE
// BEHAVIOUR
// - Reset (sync, active-high): state=IDLE, doutrx=8'h00, donerx=0, frame_err=0, busy=0.
//   Synchronizer flops reset to 1; counters and the shift register reset to 0.
// - rx passes through a 2-FF synchronizer (rx_s), then one extra flop (rx_q) for edge detection.
// - Start detect in IDLE: rx_q==1 && rx_s==0 (falling edge only).
//   A line held low (break) never re-arms until it has been seen high.
// - FSM states: IDLE -> START -> DATA -> STOP -> IDLE. Counter cnt is cleared on every state entry.
//   - START: when cnt==HALF-1, sample rx_s. If 0, go to DATA; if 1 (glitch), return to IDLE with no pulse.
//   - DATA: when cnt==CPB-1, shift rx_s into bit[bitidx] (LSB first) and clear cnt.
//     After bitidx==7 has been sampled, go to STOP.
//   - STOP: when cnt==CPB-1, sample rx_s. If 1, doutrx<=shift reg and pulse donerx.
//     If 0, pulse frame_err and leave doutrx unchanged. Return to IDLE in either case.
// - Pulses are registered and high for exactly 1 clk. donerx and frame_err are never high together.
// - Latency: donerx fires HALF+9*CPB clks after the cycle start is detected
//   (988 at defaults), plus 3 clks of synchronizer/edge-detect delay from the rx pin.
// - Back-to-back frames: a new start edge is accepted on the first IDLE cycle after STOP.
//   No idle gap is required beyond the stop bit itself.
// - Reset mid-frame: abort immediately to IDLE. The partial byte is dropped and no pulse is issued.
// - busy=1 in START/DATA/STOP, 0 in IDLE. rx changes inside a bit period are ignored.
// - cnt width = $clog2(CPB). bitidx is 3 bits, with no wrap past 7.
// STRUCTURE
// - uart_pkg (shared with the transmitter):
//   - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t
//   - function clks_per_bit(clk_rate, baud_rate)
//   - localparam UART_DATA_BITS = 8
// - Sub-module uart_sync: 2-FF synchronizer, parameterised reset value (1 here).
// - FSM, counters and the shift register stay in uart_rx.
// TESTING
// - Defaults (CPB=104). Drive 8'hA5 as 8N1 at 104 clks/bit
//   -> one donerx pulse, doutrx==8'hA5, frame_err=0, busy falls on the next cycle.
// - Two back-to-back frames 8'h00 then 8'hFF with no idle gap
//   -> two donerx pulses 1040 clks apart; doutrx ends at 8'hFF.
// - Frame 8'h3C with stop bit held low
//   -> frame_err pulse, no donerx, doutrx keeps the previous value;
//      rx held low afterwards -> no new start until rx goes high.
// - 20-clk low glitch on an idle line -> START aborts at HALF, returns to IDLE, no pulses, busy high for 52 clks.
// - Assert rst for 1 clk during data bit 4 of 8'h5A
//   -> IDLE, busy=0, doutrx=8'h00, no pulse; the next clean frame 8'h81 is received correctly.
// - Bit-period skew: send 8'hC3 at +/-3% baud
//   -> doutrx==8'hC3 in both cases; a scoreboard checks LSB-first order.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: line state encoding,
// data width and the clock-per-bit divisor.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both stages
// reset to the line's idle level so no false edge appears after reset.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs from before the edge, giving a true two-flop delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, detects the start edge, samples each bit
// at mid-period and reports good bytes on donerx or bad stop bits on frame_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_rate  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] doutrx,
  output logic                      donerx,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int CPB  = clks_per_bit(clk_rate, baud_rate);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(UART_DATA_BITS);

  localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx: clk_rate/baud_rate must be at least 4");
  end

  uart_state_t               state, state_next;
  logic                      rx_s, rx_q;
  logic [CW-1:0]             cnt;
  logic [BW-1:0]             bitidx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      cnt_clr, shift_en, done_set, err_set;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rx_q  <= 1'b1;
    end else begin
      state <= state_next;
      rx_q  <= rx_s;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        // Falling edge only: a line stuck low must go high before re-arming.
        if (rx_q && !rx_s) begin
          state_next = START;
          cnt_clr    = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_clr    = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CPB_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bitidx == BIT_LAST) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == CPB_LAST) begin
          cnt_clr    = 1'b1;
          state_next = IDLE;
          done_set   = rx_s;
          err_set    = !rx_s;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      doutrx    <= '0;
      donerx    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= (cnt_clr || state == IDLE) ? '0 : cnt + 1'b1;
      donerx    <= done_set;
      frame_err <= err_set;
      if (state != DATA) begin
        bitidx <= '0;
      end else if (shift_en) begin
        shreg[bitidx] <= rx_s;
        if (bitidx != BIT_LAST) bitidx <= bitidx + 1'b1;
      end
      if (done_set) doutrx <= shreg;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx: frames are driven as 8N1 bit
// sequences and outcomes compared with an expected-frame model.
module tb_uart_rx;

  localparam int CPB     = 104;
  localparam int HALF    = 52;
  localparam int LATENCY = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] doutrx;
  logic       donerx;
  logic       frame_err;
  logic       busy;

  uart_rx #(.clk_rate(1000000), .baud_rate(9600)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .doutrx    (doutrx),
    .donerx    (donerx),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int busy_cycles = 0;
  int both_cnt = 0;
  int busy_after_done = 0;
  logic prev_done = 1'b0;

  int         done_cyc_q[$];
  logic [7:0] done_dat_q[$];
  int         err_cyc_q[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (donerx) begin
      done_cyc_q.push_back(cyc);
      done_dat_q.push_back(doutrx);
    end
    if (frame_err) err_cyc_q.push_back(cyc);
    if (donerx && frame_err) both_cnt++;
    if (busy) busy_cycles++;
    if (prev_done && busy) busy_after_done++;
    prev_done = donerx;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Model: a high stop bit yields exactly this byte; a low one yields a frame error.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int p);
    if (stop) begin
      exp_q.push_back(d);
      start_q.push_back(cyc);
    end else begin
      exp_err++;
    end
    hold(1'b0, p);
    for (int i = 0; i < 8; i++) hold(d[i], p);
    hold(stop, p);
  endtask

  task automatic check_outcome(input string tag);
    check({tag, "_done_count"}, done_dat_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < done_dat_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), done_dat_q[i], exp_q[i]);
      check($sformatf("%s_latency%0d", tag, i), done_cyc_q[i] - start_q[i], LATENCY);
    end
    check({tag, "_err_count"}, err_cyc_q.size(), exp_err);
    done_cyc_q.delete();
    done_dat_q.delete();
    err_cyc_q.delete();
    exp_q.delete();
    start_q.delete();
    exp_err = 0;
  endtask

  initial begin
    int b0, gap;
    logic [7:0] d;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_doutrx", doutrx, 8'h00);
    check("rst_donerx", donerx, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    hold(1'b1, 20);

    send_frame(8'hA5, 1'b1, CPB);
    hold(1'b1, 30);
    check("a5_doutrx", doutrx, 8'hA5);
    check("a5_busy_idle", busy, 1'b0);
    check_outcome("a5");

    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    hold(1'b1, 30);
    gap = (done_cyc_q.size() == 2) ? done_cyc_q[1] - done_cyc_q[0] : -1;
    check("b2b_gap", gap, 10 * CPB);
    check("b2b_doutrx", doutrx, 8'hFF);
    check_outcome("b2b");

    send_frame(8'h3C, 1'b0, CPB);
    b0 = busy_cycles;
    hold(1'b0, 300);
    check("break_no_start", busy_cycles - b0, 0);
    hold(1'b1, 50);
    check("break_busy_after_high", busy_cycles - b0, 0);
    check("ferr_doutrx_kept", doutrx, 8'hFF);
    check_outcome("ferr");

    b0 = busy_cycles;
    hold(1'b0, 20);
    hold(1'b1, 150);
    check("glitch_busy_cycles", busy_cycles - b0, HALF);
    check("glitch_doutrx", doutrx, 8'hFF);
    check_outcome("glitch");

    d = 8'h5A;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(d[i], CPB);
    hold(d[4], 50);
    check("midrst_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_doutrx", doutrx, 8'h00);
    hold(1'b1, 1200);
    check_outcome("midrst");
    send_frame(8'h81, 1'b1, CPB);
    hold(1'b1, 30);
    check("after_rst_doutrx", doutrx, 8'h81);
    check_outcome("after_rst");

    send_frame(8'hC3, 1'b1, 101);
    hold(1'b1, 80);
    check("fast_doutrx", doutrx, 8'hC3);
    check_outcome("fast");
    send_frame(8'hC3, 1'b1, 107);
    hold(1'b1, 40);
    check("slow_doutrx", doutrx, 8'hC3);
    check_outcome("slow");

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b1, CPB);
    end
    hold(1'b1, 40);
    check("rand_last_doutrx", doutrx, d);
    check_outcome("rand");

    check("pulse_overlap", both_cnt, 0);
    check("busy_after_done", busy_after_done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
